// File: rtl/player_jump_ctrl_if.sv
// Signal bundle between the jump controller and its surroundings (keyboard, video timing, sprite logic).
interface player_jump_ctrl_if;
  logic       VS;
  logic [7:0] keycode;
  logic       keyPress;
  logic [1:0] gameState;
  logic [9:0] PlayerY;
  logic [9:0] PlayerYMotion;
  logic [1:0] jumpState;
  logic       airborne;
  logic       frameTick;

  modport master (
    output VS, keycode, keyPress, gameState,
    input  PlayerY, PlayerYMotion, jumpState, airborne, frameTick
  );

  modport slave (
    input  VS, keycode, keyPress, gameState,
    output PlayerY, PlayerYMotion, jumpState, airborne, frameTick
  );
endinterface

// File: rtl/player_jump_ctrl.sv
// Vertical jump/fall sequencer for the player sprite; Y and velocity advance once per video frame.
// state | meaning: GROUNDED resting | RISING moving up | FALLING moving down | LAND one-frame touchdown
module player_jump_ctrl #(
  parameter int         JUMP_V0  = 8,
  parameter int         GRAVITY  = 1,
  parameter int         MAX_FALL = 8,
  parameter int         GROUND_Y = 230,
  parameter int         Y_MIN    = 0,
  parameter logic [7:0] JUMP_KEY = 8'h29
) (
  input logic               Clk,
  input logic               Reset,
  player_jump_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    GROUNDED = 2'b00,
    RISING   = 2'b01,
    FALLING  = 2'b10,
    LAND     = 2'b11
  } jump_state_e;

  localparam logic signed [10:0] GRAV_S  = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF_S  = 11'(MAX_FALL);
  localparam logic signed [10:0] GND_S   = 11'(GROUND_Y);
  localparam logic signed [10:0] YMIN_S  = 11'(Y_MIN);
  localparam logic        [9:0]  GND_Y10 = 10'(GROUND_Y);
  localparam logic        [9:0]  YMIN10  = 10'(Y_MIN);
  localparam logic        [9:0]  MAXF10  = 10'(MAX_FALL);
  localparam logic        [9:0]  NEG_V0  = 10'(-JUMP_V0);

  logic        vs_s1_q, vs_s2_q, vs_s3_q, tick_q;
  logic [1:0]  gs_s1_q, gs_s2_q;
  logic        press_q, req_q, req_d;
  logic        air_q, air_d;
  logic [9:0]  y_q, y_d, vel_q, vel_d;
  jump_state_e state_q, state_d;

  logic        press_now, press_edge, play, tick_d;
  logic signed [10:0] y_ext, vel_ext, y_sum, vel_inc, ceil_lim;

  assign press_now  = bus.keyPress && (bus.keycode == JUMP_KEY);
  assign play       = (gs_s2_q == 2'b01);
  // Only a fresh press while on the ground counts; airborne presses are dropped outright.
  assign press_edge = press_now && !press_q && play &&
                      ((state_q == GROUNDED) || (state_q == LAND));
  assign tick_d     = vs_s2_q & ~vs_s3_q;

  // 11-bit signed views keep an overshooting Y from wrapping past the ceiling/ground tests.
  assign y_ext    = signed'({1'b0, y_q});
  assign vel_ext  = signed'({vel_q[9], vel_q});
  assign y_sum    = y_ext + vel_ext;
  assign vel_inc  = vel_ext + GRAV_S;
  assign ceil_lim = YMIN_S - vel_ext;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    req_d   = req_q | press_edge;
    if (!play) req_d = 1'b0;
    if (tick_q) begin
      if (!play) begin
        state_d = GROUNDED;
        y_d     = GND_Y10;
        vel_d   = '0;
        req_d   = 1'b0;
      end else begin
        case (state_q)
          GROUNDED: begin
            if (req_q || press_edge) begin
              state_d = RISING;
              vel_d   = NEG_V0;
              req_d   = 1'b0;
            end else begin
              vel_d = '0;
            end
          end
          RISING: begin
            if (y_ext < ceil_lim) begin
              state_d = FALLING;
              y_d     = YMIN10;
              vel_d   = '0;
            end else begin
              y_d   = y_sum[9:0];
              vel_d = vel_inc[9:0];
              if (!vel_inc[10]) state_d = FALLING;
            end
          end
          FALLING: begin
            if (y_sum >= GND_S) begin
              state_d = LAND;
              y_d     = GND_Y10;
              vel_d   = '0;
            end else begin
              y_d   = y_sum[9:0];
              vel_d = (vel_inc > MAXF_S) ? MAXF10 : vel_inc[9:0];
            end
          end
          default: begin
            state_d = GROUNDED;
            y_d     = GND_Y10;
            vel_d   = '0;
          end
        endcase
      end
    end
    air_d = (state_d == RISING) || (state_d == FALLING);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
      vs_s3_q <= 1'b0;
      tick_q  <= 1'b0;
      gs_s1_q <= 2'b00;
      gs_s2_q <= 2'b00;
      press_q <= 1'b0;
      req_q   <= 1'b0;
      state_q <= GROUNDED;
      y_q     <= GND_Y10;
      vel_q   <= '0;
      air_q   <= 1'b0;
    end else begin
      vs_s1_q <= bus.VS;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
      tick_q  <= tick_d;
      gs_s1_q <= bus.gameState;
      gs_s2_q <= gs_s1_q;
      press_q <= press_now;
      req_q   <= req_d;
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      air_q   <= air_d;
    end
  end

  assign bus.PlayerY       = y_q;
  assign bus.PlayerYMotion = vel_q;
  assign bus.jumpState     = state_q;
  assign bus.airborne      = air_q;
  assign bus.frameTick     = tick_q;

endmodule

// File: tb/tb_player_jump_ctrl.sv
// Self-checking bench: directed frame table, corner sequences and random frames against a frame-level model.
module tb_player_jump_ctrl;

  localparam int G_Y  = 230;
  localparam int V0   = 8;
  localparam int GRAV = 1;
  localparam int MAXF = 8;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic       vs    = 1'b0;
  logic [7:0] kc    = 8'h00;
  logic       kp    = 1'b0;
  logic [1:0] gs    = 2'b01;

  always #5 Clk = ~Clk;

  player_jump_ctrl_if ifa ();
  player_jump_ctrl_if ifb ();

  assign ifa.VS = vs;  assign ifa.keycode = kc;  assign ifa.keyPress = kp;  assign ifa.gameState = gs;
  assign ifb.VS = vs;  assign ifb.keycode = kc;  assign ifb.keyPress = kp;  assign ifb.gameState = gs;

  player_jump_ctrl dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
  player_jump_ctrl #(.Y_MIN(210)) dut_c (.Clk(Clk), .Reset(Reset), .bus(ifb));

  typedef struct {
    int st;
    int y;
    int vel;
    bit req;
  } mdl_t;

  typedef struct {
    bit key;
    int y;  int vel; int st;
    int yc; int vc;  int sc;
  } vec_t;

  mdl_t m[2];
  int   ymin[2] = '{0, 210};
  bit   m_play  = 1'b1;
  bit   m_prev  = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  vec_t tbl[20];

  function automatic mdl_t mdl_step(input mdl_t s, input int yl, input bit play);
    mdl_t n;
    n = s;
    if (!play) begin
      n.st = 0; n.y = G_Y; n.vel = 0; n.req = 1'b0;
      return n;
    end
    case (s.st)
      0: if (s.req) begin n.st = 1; n.vel = -V0; n.req = 1'b0; end
         else n.vel = 0;
      1: if (s.y < yl + (-s.vel)) begin n.y = yl; n.vel = 0; n.st = 2; end
         else begin
           n.y = s.y + s.vel; n.vel = s.vel + GRAV;
           if (n.vel >= 0) n.st = 2;
         end
      2: if (s.y + s.vel >= G_Y) begin n.y = G_Y; n.vel = 0; n.st = 3; end
         else begin
           n.y = s.y + s.vel;
           n.vel = (s.vel + GRAV > MAXF) ? MAXF : s.vel + GRAV;
         end
      default: begin n.st = 0; n.y = G_Y; n.vel = 0; end
    endcase
    return n;
  endfunction

  function automatic void mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].st = 0; m[k].y = G_Y; m[k].vel = 0; m[k].req = 1'b0;
    end
    m_prev = 1'b0;
  endfunction

  function automatic void key_event();
    bit lvl;
    lvl = kp && (kc == 8'h29);
    if (lvl && !m_prev && m_play)
      for (int k = 0; k < 2; k++)
        if (m[k].st == 0 || m[k].st == 3) m[k].req = 1'b1;
    m_prev = lvl;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("A.y",   int'(ifa.PlayerY), m[0].y);
    chk("A.vel", int'($signed(ifa.PlayerYMotion)), m[0].vel);
    chk("A.st",  int'(ifa.jumpState), m[0].st);
    chk("A.air", int'(ifa.airborne), (m[0].st == 1 || m[0].st == 2) ? 1 : 0);
    chk("C.y",   int'(ifb.PlayerY), m[1].y);
    chk("C.vel", int'($signed(ifb.PlayerYMotion)), m[1].vel);
    chk("C.st",  int'(ifb.jumpState), m[1].st);
    chk("C.air", int'(ifb.airborne), (m[1].st == 1 || m[1].st == 2) ? 1 : 0);
  endtask

  task automatic chk_rest(input string nm);
    chk({nm, ".A.y"},    int'(ifa.PlayerY), G_Y);
    chk({nm, ".A.vel"},  int'(ifa.PlayerYMotion), 0);
    chk({nm, ".A.st"},   int'(ifa.jumpState), 0);
    chk({nm, ".A.air"},  int'(ifa.airborne), 0);
    chk({nm, ".A.tick"}, int'(ifa.frameTick), 0);
    chk({nm, ".C.y"},    int'(ifb.PlayerY), G_Y);
    chk({nm, ".C.st"},   int'(ifb.jumpState), 0);
  endtask

  task automatic set_keys(input logic p, input logic [7:0] c);
    @(negedge Clk);
    kp = p;
    kc = c;
    key_event();
  endtask

  task automatic set_gs(input logic [1:0] v);
    @(negedge Clk);
    gs = v;
    m_play = (v == 2'b01);
    if (!m_play) begin
      m[0].req = 1'b0;
      m[1].req = 1'b0;
    end
    repeat (3) @(negedge Clk);
  endtask

  // One video frame: VS rises on a falling Clk edge, the tick must show on the third rising edge after.
  task automatic frame(input bit press_at_tick);
    @(negedge Clk);
    vs = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      chk("frameTick", int'(ifa.frameTick), (i == 3) ? 1 : 0);
      if (i == 3 && press_at_tick) begin
        kp = 1'b1;
        kc = 8'h29;
        key_event();
      end
    end
    for (int k = 0; k < 2; k++) m[k] = mdl_step(m[k], ymin[k], m_play);
    chk_models();
    vs = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int launches;
    int prev_st;
    int n;

    tbl = '{
      '{1'b1, 230, -8, 1, 230, -8, 1},
      '{1'b0, 222, -7, 1, 222, -7, 1},
      '{1'b0, 215, -6, 1, 215, -6, 1},
      '{1'b0, 209, -5, 1, 210,  0, 2},
      '{1'b1, 204, -4, 1, 210,  1, 2},
      '{1'b0, 200, -3, 1, 211,  2, 2},
      '{1'b0, 197, -2, 1, 213,  3, 2},
      '{1'b0, 195, -1, 1, 216,  4, 2},
      '{1'b0, 194,  0, 2, 220,  5, 2},
      '{1'b0, 194,  1, 2, 225,  6, 2},
      '{1'b0, 195,  2, 2, 230,  0, 3},
      '{1'b0, 197,  3, 2, 230,  0, 0},
      '{1'b0, 200,  4, 2, 230,  0, 0},
      '{1'b0, 204,  5, 2, 230,  0, 0},
      '{1'b0, 209,  6, 2, 230,  0, 0},
      '{1'b0, 215,  7, 2, 230,  0, 0},
      '{1'b0, 222,  8, 2, 230,  0, 0},
      '{1'b0, 230,  0, 3, 230,  0, 0},
      '{1'b0, 230,  0, 0, 230,  0, 0},
      '{1'b0, 230,  0, 0, 230,  0, 0}
    };

    mdl_reset();
    repeat (3) @(negedge Clk);
    chk_rest("reset");
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    repeat (3) frame(1'b0);

    // Single jump; a second press at tick 4 lands while airborne and must be ignored.
    for (int i = 0; i < 20; i++) begin
      set_keys(tbl[i].key, 8'h29);
      frame(1'b0);
      chk("tbl.A.y",   int'(ifa.PlayerY), tbl[i].y);
      chk("tbl.A.vel", int'($signed(ifa.PlayerYMotion)), tbl[i].vel);
      chk("tbl.A.st",  int'(ifa.jumpState), tbl[i].st);
      chk("tbl.C.y",   int'(ifb.PlayerY), tbl[i].yc);
      chk("tbl.C.vel", int'($signed(ifb.PlayerYMotion)), tbl[i].vc);
      chk("tbl.C.st",  int'(ifb.jumpState), tbl[i].sc);
    end

    // Held key gives exactly one jump.
    set_keys(1'b1, 8'h29);
    launches = 0;
    for (int i = 0; i < 40; i++) begin
      prev_st = int'(ifa.jumpState);
      frame(1'b0);
      if (prev_st == 0 && int'(ifa.jumpState) == 1) launches++;
    end
    chk("hold_launches", launches, 1);

    // Jump, then release and re-press during LAND: relaunch on the first GROUNDED tick.
    set_keys(1'b0, 8'h29);
    set_keys(1'b1, 8'h29);
    n = 0;
    while (n < 30 && int'(ifa.jumpState) != 3) begin
      frame(1'b0);
      n++;
    end
    chk("reach_land", int'(ifa.jumpState), 3);
    set_keys(1'b0, 8'h29);
    set_keys(1'b1, 8'h29);
    frame(1'b0);
    chk("land_to_ground", int'(ifa.jumpState), 0);
    frame(1'b0);
    chk("relaunch", int'(ifa.jumpState), 1);
    set_keys(1'b0, 8'h29);
    repeat (20) frame(1'b0);

    // Press edge in the tick cycle is taken by that tick.
    frame(1'b1);
    chk("same_cycle_launch", int'(ifa.jumpState), 1);
    chk("same_cycle_vel", int'($signed(ifa.PlayerYMotion)), -V0);
    set_keys(1'b0, 8'h29);
    repeat (5) frame(1'b0);

    // Asynchronous reset mid-jump.
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 chk_rest("midreset");
    mdl_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    repeat (2) frame(1'b0);

    // Leaving PLAY mid-jump snaps to ground and ignores presses.
    set_keys(1'b1, 8'h29);
    repeat (3) frame(1'b0);
    set_keys(1'b0, 8'h29);
    set_gs(2'b00);
    frame(1'b0);
    chk("nonplay.y", int'(ifa.PlayerY), G_Y);
    chk("nonplay.st", int'(ifa.jumpState), 0);
    set_keys(1'b1, 8'h29);
    frame(1'b0);
    chk("nonplay_press", int'(ifa.jumpState), 0);
    set_keys(1'b0, 8'h29);
    set_gs(2'b01);
    frame(1'b0);
    chk("replay_no_req", int'(ifa.jumpState), 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_gs(($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01);
      case ($urandom_range(0, 3))
        0: set_keys(1'b1, 8'h29);
        1: set_keys(1'b0, kc);
        2: set_keys(1'b1, 8'($urandom_range(0, 255)));
        default: ;
      endcase
      frame($urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
